// File: rtl/clk_div_gen.sv
// Multi-channel clock divider / clock-enable generator with runtime ratios.
// Ratio changes are staged and take effect at a period boundary or on a global sync.
module clk_div_gen #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DIV_W  = 8,
  parameter logic [NUM_CH*DIV_W-1:0] INIT_DIV = {8'd32, 8'd16},
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] div_clk_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] pend_o
);

  logic [DIV_W-1:0] act_q  [NUM_CH];
  logic [DIV_W-1:0] act_d  [NUM_CH];
  logic [DIV_W-1:0] pval_q [NUM_CH];
  logic [DIV_W-1:0] pval_d [NUM_CH];
  logic [DIV_W-1:0] cnt_q  [NUM_CH];
  logic [DIV_W-1:0] cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] pflag_d, div_d, tick_d;

  logic             wr;
  logic             en;
  logic             apply;
  logic [DIV_W-1:0] n;
  logic [DIV_W:0]   h;

  // A write is only visible as pending for at least one cycle; staged ratios
  // are consumed at the following boundary, except a sync which takes the
  // write of its own cycle directly.
  always_comb begin
    wr      = 1'b0;
    en      = 1'b0;
    apply   = 1'b0;
    n       = '0;
    h       = '0;
    pflag_d = pend_o;
    div_d   = '0;
    tick_d  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wr         = cfg_wr && (32'(cfg_ch) == c);
      act_d[c]   = act_q[c];
      pval_d[c]  = wr ? cfg_div : pval_q[c];
      cnt_d[c]   = cnt_q[c];
      pflag_d[c] = pend_o[c] | wr;
      en         = act_q[c] >= DIV_W'(2);
      n          = pend_o[c] ? pval_q[c] : act_q[c];
      apply      = 1'b0;
      if (sync_i) begin
        if (wr) n = cfg_div;
        apply      = 1'b1;
        pflag_d[c] = 1'b0;
      end else if (!en || (cnt_q[c] >= act_q[c] - DIV_W'(1))) begin
        apply      = 1'b1;
        pflag_d[c] = wr;
      end
      if (apply) begin
        act_d[c] = n;
        if (n >= DIV_W'(2)) begin
          cnt_d[c]  = '0;
          div_d[c]  = 1'b1;
          tick_d[c] = 1'b1;
        end
      end else begin
        h         = ({1'b0, act_q[c]} + (DIV_W+1)'(1)) >> 1;
        cnt_d[c]  = cnt_q[c] + DIV_W'(1);
        div_d[c]  = ({1'b0, cnt_q[c]} + (DIV_W+1)'(1)) < h;
      end
    end
  end

  // Counters reset to all-ones so the first edge after release is a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        act_q[c]  <= INIT_DIV[c*DIV_W +: DIV_W];
        pval_q[c] <= '0;
        cnt_q[c]  <= '1;
      end
      pend_o    <= '0;
      div_clk_o <= '0;
      tick_o    <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        act_q[c]  <= act_d[c];
        pval_q[c] <= pval_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      pend_o    <= pflag_d;
      div_clk_o <= div_d;
      tick_o    <= tick_d;
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus random traffic
// against a period-start-time reference model.
module tb_clk_div_gen;
  localparam int NC = 3;
  localparam int DW = 8;
  localparam logic [NC*DW-1:0] INIT = {8'd0, 8'd32, 8'd16};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [DW-1:0] cfg_div = '0;
  logic          sync_i = 1'b0;
  logic [NC-1:0] div_clk_o, tick_o, pend_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_gen #(.NUM_CH(NC), .DIV_W(DW), .INIT_DIV(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .sync_i(sync_i), .div_clk_o(div_clk_o),
    .tick_o(tick_o), .pend_o(pend_o)
  );

  // Reference: each channel is described by its ratio and the edge index at
  // which its current period began.
  int m_n[NC], m_start[NC], m_pval[NC];
  bit m_pend[NC];
  bit m_fresh;
  int cyc;

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_n[c] = int'(INIT[c*DW +: DW]);
      m_pend[c] = 1'b0;
      m_pval[c] = 0;
      m_start[c] = 0;
    end
    m_fresh = 1'b1;
    cyc = 0;
  endfunction

  function automatic void model_edge(bit wr, int ch, int dv, bit sy);
    cyc++;
    for (int c = 0; c < NC; c++) begin
      bit w = wr && (ch == c);
      int nn = m_pend[c] ? m_pval[c] : m_n[c];
      bit app = 1'b0;
      if (sy) begin
        if (w) nn = dv;
        app = 1'b1;
        m_pend[c] = 1'b0;
      end else if (m_fresh || m_n[c] < 2 || (cyc - m_start[c]) >= m_n[c]) begin
        app = 1'b1;
        m_pend[c] = 1'b0;
      end
      if (app) begin
        m_n[c] = nn;
        if (nn >= 2) m_start[c] = cyc;
      end
      if (w && !sy) begin
        m_pend[c] = 1'b1;
        m_pval[c] = dv;
      end
    end
    m_fresh = 1'b0;
  endfunction

  function automatic logic [NC-1:0] exp_div();
    logic [NC-1:0] r = '0;
    for (int c = 0; c < NC; c++)
      r[c] = (m_n[c] >= 2) && ((cyc - m_start[c]) < (m_n[c] + 1) / 2);
    return r;
  endfunction

  function automatic logic [NC-1:0] exp_tick();
    logic [NC-1:0] r = '0;
    for (int c = 0; c < NC; c++)
      r[c] = (m_n[c] >= 2) && (cyc == m_start[c]);
    return r;
  endfunction

  function automatic logic [NC-1:0] exp_pend();
    logic [NC-1:0] r = '0;
    for (int c = 0; c < NC; c++) r[c] = m_pend[c];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit wr, input int ch, input int dv, input bit sy);
    cfg_wr = wr;
    cfg_ch = ch[1:0];
    cfg_div = dv[DW-1:0];
    sync_i = sy;
    @(posedge clk);
    model_edge(wr, ch, dv, sy);
    #1;
    cfg_wr = 1'b0;
    sync_i = 1'b0;
    chk("div_clk", 8'(div_clk_o), 8'(exp_div()));
    chk("tick", 8'(tick_o), 8'(exp_tick()));
    chk("pend", 8'(pend_o), 8'(exp_pend()));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_div", 8'(div_clk_o), 8'h00);
    chk("reset_tick", 8'(tick_o), 8'h00);
    chk("reset_pend", 8'(pend_o), 8'h00);
    #2 rst_n = 1'b1;

    // Defaults: both enabled channels start together; disabled ch2 stays quiet.
    step(1'b0, 0, 0, 1'b0);
    chk("first_tick", 8'(tick_o), 8'h03);
    chk("first_div", 8'(div_clk_o), 8'h03);
    idle(66);

    // Ratio 5 written in the third cycle of a ch0 period.
    for (int i = 0; i < 20 && (cyc - m_start[0]) != 2; i++) step(1'b0, 0, 0, 1'b0);
    step(1'b1, 0, 5, 1'b0);
    chk("pend_after_wr", 8'(pend_o[0]), 8'h01);
    idle(40);

    // Back-to-back writes to ch1: last one wins.
    step(1'b1, 1, 10, 1'b0);
    step(1'b1, 1, 6, 1'b0);
    idle(50);

    // Disable ch0, then re-enable with ratio 4 from a disabled state.
    step(1'b1, 0, 0, 1'b0);
    idle(20);
    chk("disabled_div", 8'(div_clk_o[0]), 8'h00);
    chk("disabled_tick", 8'(tick_o[0]), 8'h00);
    step(1'b1, 0, 4, 1'b0);
    chk("reen_pend", 8'(pend_o[0]), 8'h01);
    step(1'b0, 0, 0, 1'b0);
    chk("reen_tick", 8'(tick_o[0]), 8'h01);
    idle(13);

    // Sync with a same-cycle write to ch1.
    step(1'b1, 1, 7, 1'b1);
    chk("sync_tick", 8'(tick_o[1:0]), 8'h03);
    chk("sync_pend", 8'(pend_o), 8'h00);
    idle(20);

    // Consecutive syncs hold both ticks high.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 0, 1'b1);
      chk("sync_hold", 8'(tick_o[1:0] & div_clk_o[1:0]), 8'h03);
    end
    idle(10);

    // Write to a nonexistent channel has no effect.
    step(1'b1, 3, 9, 1'b0);
    chk("bad_ch_pend", 8'(pend_o), 8'h00);
    idle(30);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r = int'($urandom_range(0, 63));
      int dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 9));
      step(r < 5, int'($urandom_range(0, 3)), dv, r == 63);
    end

    // Asynchronous reset mid-period.
    step(1'b1, 1, 3, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_div", 8'(div_clk_o), 8'h00);
    chk("async_tick", 8'(tick_o), 8'h00);
    chk("async_pend", 8'(pend_o), 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 0, 0, 1'b0);
    chk("rerelease_tick", 8'(tick_o), 8'h03);
    idle(70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
